// File: rtl/decode_queue_if.sv
// Fetch/issue handshake bundle for decode_queue: push side, pop side, flush and occupancy.
// master is the surrounding pipeline, slave is the queue itself.
interface decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_inscode;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [4:0]        out_sa;
    logic [15:0]       out_imm;
    logic [25:0]       out_target;
    logic [PC_W-1:0]   out_pc;
    logic              out_ri;
    logic              out_ds;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inscode, out_rs, out_rt, out_rd, out_sa,
               out_imm, out_target, out_pc, out_ri, out_ds, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inscode, out_rs, out_rt, out_rd, out_sa,
               out_imm, out_target, out_pc, out_ri, out_ds, count
    );
endinterface

// File: rtl/decode_queue.sv
// Instruction-decode buffer: MIPS32 words are decoded on push and held in a
// DEPTH-entry in-order queue with delay-slot tagging and pipeline flush.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_queue_if.slave io_bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [5:0] {
        C_RI     = 6'd0,  C_ADD    = 6'd1,  C_ADDI   = 6'd2,  C_ADDU   = 6'd3,
        C_ADDIU  = 6'd4,  C_SUB    = 6'd5,  C_SUBU   = 6'd6,  C_SLT    = 6'd7,
        C_SLTI   = 6'd8,  C_SLTU   = 6'd9,  C_SLTIU  = 6'd10, C_DIV    = 6'd11,
        C_DIVU   = 6'd12, C_MULT   = 6'd13, C_MULTU  = 6'd14, C_AND    = 6'd15,
        C_ANDI   = 6'd16, C_LUI    = 6'd17, C_NOR    = 6'd18, C_OR     = 6'd19,
        C_ORI    = 6'd20, C_XOR    = 6'd21, C_XORI   = 6'd22, C_SLL    = 6'd23,
        C_SLLV   = 6'd24, C_SRA    = 6'd25, C_SRAV   = 6'd26, C_SRL    = 6'd27,
        C_SRLV   = 6'd28, C_BEQ    = 6'd29, C_BNE    = 6'd30, C_BGEZ   = 6'd31,
        C_BGTZ   = 6'd32, C_BLEZ   = 6'd33, C_BLTZ   = 6'd34, C_BLTZAL = 6'd35,
        C_BGEZAL = 6'd36, C_J      = 6'd37, C_JAL    = 6'd38, C_JR     = 6'd39,
        C_JALR   = 6'd40, C_MFHI   = 6'd41, C_MFLO   = 6'd42, C_MTHI   = 6'd43,
        C_MTLO   = 6'd44, C_BREAK  = 6'd45, C_SYSCALL= 6'd46, C_LB     = 6'd47,
        C_LBU    = 6'd48, C_LH     = 6'd49, C_LHU    = 6'd50, C_LW     = 6'd51,
        C_SB     = 6'd52, C_SH     = 6'd53, C_SW     = 6'd54, C_ERET   = 6'd55,
        C_MFC0   = 6'd56, C_MTC0   = 6'd57
    } inscode_e;

    // SPECIAL decodes on funct, REGIMM on rt, COP0 on rs (ERET also needs funct)
    function automatic inscode_e f_decode(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] funct);
        inscode_e c;
        c = C_RI;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000: c = C_ADD;     6'b100001: c = C_ADDU;
                    6'b100010: c = C_SUB;     6'b100011: c = C_SUBU;
                    6'b101010: c = C_SLT;     6'b101011: c = C_SLTU;
                    6'b011010: c = C_DIV;     6'b011011: c = C_DIVU;
                    6'b011000: c = C_MULT;    6'b011001: c = C_MULTU;
                    6'b100100: c = C_AND;     6'b100111: c = C_NOR;
                    6'b100101: c = C_OR;      6'b100110: c = C_XOR;
                    6'b000000: c = C_SLL;     6'b000100: c = C_SLLV;
                    6'b000011: c = C_SRA;     6'b000111: c = C_SRAV;
                    6'b000010: c = C_SRL;     6'b000110: c = C_SRLV;
                    6'b001000: c = C_JR;      6'b001001: c = C_JALR;
                    6'b010000: c = C_MFHI;    6'b010010: c = C_MFLO;
                    6'b010001: c = C_MTHI;    6'b010011: c = C_MTLO;
                    6'b001101: c = C_BREAK;   6'b001100: c = C_SYSCALL;
                    default:   c = C_RI;
                endcase
            end
            6'b000001: begin
                case (rt)
                    5'b00000: c = C_BLTZ;
                    5'b00001: c = C_BGEZ;
                    5'b10000: c = C_BLTZAL;
                    5'b10001: c = C_BGEZAL;
                    default:  c = C_RI;
                endcase
            end
            6'b010000: begin
                if (rs == 5'b00000)
                    c = C_MFC0;
                else if (rs == 5'b00100)
                    c = C_MTC0;
                else if (rs == 5'b10000 && funct == 6'b011000)
                    c = C_ERET;
            end
            6'b001000: c = C_ADDI;    6'b001001: c = C_ADDIU;
            6'b001010: c = C_SLTI;    6'b001011: c = C_SLTIU;
            6'b001100: c = C_ANDI;    6'b001111: c = C_LUI;
            6'b001101: c = C_ORI;     6'b001110: c = C_XORI;
            6'b000100: c = C_BEQ;     6'b000101: c = C_BNE;
            6'b000111: c = C_BGTZ;    6'b000110: c = C_BLEZ;
            6'b000010: c = C_J;       6'b000011: c = C_JAL;
            6'b100000: c = C_LB;      6'b100100: c = C_LBU;
            6'b100001: c = C_LH;      6'b100101: c = C_LHU;
            6'b100011: c = C_LW;      6'b101000: c = C_SB;
            6'b101001: c = C_SH;      6'b101011: c = C_SW;
            default:   c = C_RI;
        endcase
        return c;
    endfunction

    logic [5:0]       r_code [DEPTH];
    logic [25:0]      r_fld  [DEPTH];
    logic [PC_W-1:0]  r_pc   [DEPTH];
    logic             r_ds   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_br_pend;

    inscode_e         w_code;
    logic             w_is_branch;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [5:0]       w_hcode;
    logic [25:0]      w_hfld;
    logic [PC_W-1:0]  w_hpc;
    logic             w_hds;

    always_comb begin
        w_code      = f_decode(io_bus.in_inst[31:26], io_bus.in_inst[25:21],
                               io_bus.in_inst[20:16], io_bus.in_inst[5:0]);
        w_is_branch = (w_code >= C_BEQ) && (w_code <= C_JALR);
    end

    // Full blocks push even when popping: no bypass of the occupancy check
    assign w_in_ready  = (r_count < CNT_W'(DEPTH)) & ~rst;
    assign w_out_valid = (r_count != '0);
    assign w_push      = io_bus.in_valid & w_in_ready & ~io_bus.flush;
    assign w_pop       = w_out_valid & io_bus.out_ready & ~io_bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_br_pend <= 1'b0;
        end else if (io_bus.flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_br_pend <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail    <= r_tail + PTR_W'(1);
                r_br_pend <= w_is_branch;
            end
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_code[r_tail] <= w_code;
            r_fld[r_tail]  <= io_bus.in_inst[25:0];
            r_pc[r_tail]   <= io_bus.in_pc;
            r_ds[r_tail]   <= r_br_pend;
        end
    end

    // Storage is not reset, so every payload bit is gated by out_valid
    always_comb begin
        w_hcode = '0;
        w_hfld  = '0;
        w_hpc   = '0;
        w_hds   = 1'b0;
        if (w_out_valid) begin
            w_hcode = r_code[r_head];
            w_hfld  = r_fld[r_head];
            w_hpc   = r_pc[r_head];
            w_hds   = r_ds[r_head];
        end
    end

    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.out_valid   = w_out_valid;
    assign io_bus.out_inscode = w_hcode;
    assign io_bus.out_rs      = w_hfld[25:21];
    assign io_bus.out_rt      = w_hfld[20:16];
    assign io_bus.out_rd      = w_hfld[15:11];
    assign io_bus.out_sa      = w_hfld[10:6];
    assign io_bus.out_imm     = w_hfld[15:0];
    assign io_bus.out_target  = w_hfld;
    assign io_bus.out_pc      = w_hpc;
    assign io_bus.out_ri      = w_out_valid & (w_hcode == 6'd0);
    assign io_bus.out_ds      = w_hds;
    assign io_bus.count       = r_count;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed decode vectors, multi-cycle corner sequences
// and random traffic compared against a mask/match decode table and a queue model.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    typedef struct { logic [31:0] mask; logic [31:0] match; logic [5:0] code; } rule_t;
    typedef struct { logic [5:0] code; logic [31:0] inst; logic [31:0] pc; logic ds; } ent_t;
    typedef struct { logic [31:0] inst; logic [5:0] code; } vec_t;

    rule_t rules[$];
    ent_t  mq[$];
    logic  m_br;
    logic  m_pushed;
    int    checks = 0;
    int    errors = 0;

    function automatic void add_r(input logic [5:0] funct, input int code);
        rules.push_back('{32'hFC00003F, {26'b0, funct}, 6'(code)});
    endfunction
    function automatic void add_i(input logic [5:0] op, input int code);
        rules.push_back('{32'hFC000000, {op, 26'b0}, 6'(code)});
    endfunction
    function automatic void add_rt(input logic [4:0] rt, input int code);
        rules.push_back('{32'hFC1F0000, {6'b000001, 5'b0, rt, 16'b0}, 6'(code)});
    endfunction

    function automatic void init_rules();
        add_r(6'h20, 1);  add_r(6'h21, 3);  add_r(6'h22, 5);  add_r(6'h23, 6);
        add_r(6'h2A, 7);  add_r(6'h2B, 9);  add_r(6'h1A, 11); add_r(6'h1B, 12);
        add_r(6'h18, 13); add_r(6'h19, 14); add_r(6'h24, 15); add_r(6'h27, 18);
        add_r(6'h25, 19); add_r(6'h26, 21); add_r(6'h00, 23); add_r(6'h04, 24);
        add_r(6'h03, 25); add_r(6'h07, 26); add_r(6'h02, 27); add_r(6'h06, 28);
        add_r(6'h08, 39); add_r(6'h09, 40); add_r(6'h10, 41); add_r(6'h12, 42);
        add_r(6'h11, 43); add_r(6'h13, 44); add_r(6'h0D, 45); add_r(6'h0C, 46);
        add_i(6'h08, 2);  add_i(6'h09, 4);  add_i(6'h0A, 8);  add_i(6'h0B, 10);
        add_i(6'h0C, 16); add_i(6'h0F, 17); add_i(6'h0D, 20); add_i(6'h0E, 22);
        add_i(6'h04, 29); add_i(6'h05, 30); add_i(6'h07, 32); add_i(6'h06, 33);
        add_i(6'h02, 37); add_i(6'h03, 38); add_i(6'h20, 47); add_i(6'h24, 48);
        add_i(6'h21, 49); add_i(6'h25, 50); add_i(6'h23, 51); add_i(6'h28, 52);
        add_i(6'h29, 53); add_i(6'h2B, 54);
        add_rt(5'h01, 31); add_rt(5'h00, 34); add_rt(5'h10, 35); add_rt(5'h11, 36);
        rules.push_back('{32'hFFE0003F, 32'h42000018, 6'd55});
        rules.push_back('{32'hFFE00000, 32'h40000000, 6'd56});
        rules.push_back('{32'hFFE00000, 32'h40800000, 6'd57});
    endfunction

    function automatic logic [5:0] model_decode(input logic [31:0] inst);
        foreach (rules[i])
            if ((inst & rules[i].mask) == rules[i].match)
                return rules[i].code;
        return 6'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_payload_zero(input string tag);
        chk({tag, "_inscode"}, 32'(bus.out_inscode), 0);
        chk({tag, "_rs"}, 32'(bus.out_rs), 0);
        chk({tag, "_rt"}, 32'(bus.out_rt), 0);
        chk({tag, "_rd"}, 32'(bus.out_rd), 0);
        chk({tag, "_sa"}, 32'(bus.out_sa), 0);
        chk({tag, "_imm"}, 32'(bus.out_imm), 0);
        chk({tag, "_target"}, 32'(bus.out_target), 0);
        chk({tag, "_pc"}, bus.out_pc, 0);
        chk({tag, "_ri"}, 32'(bus.out_ri), 0);
        chk({tag, "_ds"}, 32'(bus.out_ds), 0);
    endtask

    task automatic check_model();
        ent_t e;
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(bus.count), 32'(mq.size()));
        if (mq.size() != 0) begin
            e = mq[0];
            chk("head_code", 32'(bus.out_inscode), 32'(e.code));
            chk("head_ri", 32'(bus.out_ri), 32'(e.code == 6'd0));
            chk("head_rs", 32'(bus.out_rs), 32'(e.inst[25:21]));
            chk("head_rt", 32'(bus.out_rt), 32'(e.inst[20:16]));
            chk("head_rd", 32'(bus.out_rd), 32'(e.inst[15:11]));
            chk("head_sa", 32'(bus.out_sa), 32'(e.inst[10:6]));
            chk("head_imm", 32'(bus.out_imm), 32'(e.inst[15:0]));
            chk("head_target", 32'(bus.out_target), 32'(e.inst[25:0]));
            chk("head_pc", bus.out_pc, e.pc);
            chk("head_ds", 32'(bus.out_ds), 32'(e.ds));
        end else begin
            check_payload_zero("empty");
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, check at next negedge
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic pop;
        logic [5:0] code;
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        m_pushed = v && !fl && (mq.size() < DEPTH);
        pop      = rdy && !fl && (mq.size() != 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_br = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pushed) begin
                code = model_decode(inst);
                mq.push_back('{code, inst, pc, m_br});
                m_br = (code >= 6'd29) && (code <= 6'd40);
            end
        end
        @(negedge clk);
        check_model();
    endtask

    vec_t        vecs[$];
    logic [31:0] w4[4];
    int          c4[4];
    logic [31:0] dsw[6];
    logic        dse[6];
    logic        accepted;
    rule_t       r;
    logic [31:0] inst;

    initial begin
        init_rules();
        m_br = 1'b0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0;
        bus.in_pc = '0;   bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        check_payload_zero("rst");
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        check_model();

        vecs = '{'{32'h012A4020, 6'd1},  '{32'h3C011234, 6'd17}, '{32'h00000000, 6'd23},
                 '{32'h42000018, 6'd55}, '{32'hFC000000, 6'd0},  '{32'h40000000, 6'd56},
                 '{32'h40800000, 6'd57}, '{32'h11090003, 6'd29}, '{32'h08000000, 6'd37},
                 '{32'h0C000000, 6'd38}, '{32'h04110000, 6'd36}, '{32'h04100000, 6'd35},
                 '{32'h04000000, 6'd34}, '{32'h04010000, 6'd31}, '{32'h42000000, 6'd0},
                 '{32'h0000000C, 6'd46}, '{32'h0000000D, 6'd45}, '{32'h8C000000, 6'd51},
                 '{32'hAC000000, 6'd54}, '{32'h03E00008, 6'd39}, '{32'h00000009, 6'd40},
                 '{32'h00000010, 6'd41}, '{32'h0000001A, 6'd11}, '{32'h0000003F, 6'd0},
                 '{32'h74000000, 6'd0},  '{32'h1C000000, 6'd32}, '{32'h04020000, 6'd0}};
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].inst, 32'(i * 4), 1'b0, 1'b0);
            chk("vec_code", 32'(bus.out_inscode), 32'(vecs[i].code));
            chk("vec_ri", 32'(bus.out_ri), 32'(vecs[i].code == 6'd0));
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
        end

        w4 = '{32'h012A4020, 32'h3C011234, 32'h00000000, 32'h42000018};
        c4 = '{1, 17, 23, 55};
        for (int i = 0; i < 4; i++) cycle(1'b1, w4[i], 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("seq_code", 32'(bus.out_inscode), 32'(c4[i]));
            chk("seq_ri", 32'(bus.out_ri), 0);
            if (i == 0) begin
                chk("seq_rs", 32'(bus.out_rs), 9);
                chk("seq_rt", 32'(bus.out_rt), 10);
                chk("seq_rd", 32'(bus.out_rd), 8);
            end
            if (i == 1) chk("seq_imm", 32'(bus.out_imm), 32'h1234);
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
        end

        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        dsw = '{32'h11090003, 32'h012A4020, 32'h012A4020, 32'h08000000, 32'h0C000000, 32'h012A4020};
        dse = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, dsw[i], 32'h200 + 32'(i * 4), 1'b1, 1'b0);
            chk("ds_tag", 32'(bus.out_ds), 32'(dse[i]));
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h012A4020, 32'(i * 4), 1'b0, 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_count", 32'(bus.count), 4);
        cycle(1'b1, 32'h3C011234, 32'h10, 1'b0, 1'b0);
        chk("full_hold_count", 32'(bus.count), 4);
        accepted = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("full_pop_pc", bus.out_pc, 32'(k * 4));
            cycle(!accepted, 32'h3C011234, 32'h10, 1'b1, 1'b0);
            if (m_pushed) accepted = 1'b1;
        end

        for (int i = 0; i < 2; i++) cycle(1'b1, 32'h00851020 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, $urandom, 32'h400 + 32'(i * 4), 1'b1, 1'b0);
            chk("pp_count", 32'(bus.count), 2);
        end

        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b1, 32'h11090003, 32'h500, 1'b0, 1'b0);
        cycle(1'b1, 32'h012A4020, 32'h504, 1'b0, 1'b0);
        cycle(1'b1, 32'h11090003, 32'h508, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(bus.count), 3);
        cycle(1'b1, 32'h012A4020, 32'h50C, 1'b1, 1'b1);
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        cycle(1'b1, 32'h012A4020, 32'h50C, 1'b0, 1'b0);
        chk("flush_repush_ds", 32'(bus.out_ds), 0);
        chk("flush_repush_pc", bus.out_pc, 32'h50C);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) inst = $urandom;
            else begin
                r = rules[$urandom_range(0, rules.size() - 1)];
                inst = ($urandom & ~r.mask) | r.match;
            end
            cycle($urandom_range(0, 3) != 0, inst, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        end

        cycle(1'b1, 32'h012A4020, 32'h600, 1'b0, 1'b0);
        cycle(1'b1, 32'h11090003, 32'h604, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 0);
        chk("async_rst_count", 32'(bus.count), 0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 0);
        mq.delete();
        m_br = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_model();
        cycle(1'b1, 32'h012A4020, 32'h700, 1'b0, 1'b0);
        chk("post_async_ds", 32'(bus.out_ds), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
